// File: rtl/nim_pkg.sv
// Shared types and constants for the NIM pulse-pair generator.
package nim_pkg;

    localparam int unsigned NIM_CHANNELS = 4;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        STOP_WAIT,
        HOLD
    } nim_gen_state_t;

    typedef logic [1:0] nim_sel_t;

endpackage

// File: rtl/nim_pulse_pair_gen_if.sv
// Interval-word stream: host pushes 32-bit start-to-stop intervals with valid/ready.
interface nim_pulse_pair_gen_if;

    logic [31:0] data;
    logic        valid;
    logic        ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );

endinterface

// File: rtl/nim_pulse_stretcher.sv
// One-shot: active for exactly i_width cycles starting the cycle after i_fire.
// A re-fire while active restarts the count.
module nim_pulse_stretcher #(
    parameter int unsigned PW_BITS = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_fire,
    input  logic [PW_BITS-1:0] i_width,
    output logic               o_active_next,
    output logic               o_last
);

    logic [PW_BITS-1:0] r_cnt;
    logic [PW_BITS-1:0] w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt;
        if (i_fire) begin
            w_cnt_d = i_width;
        end else if (r_cnt != '0) begin
            w_cnt_d = r_cnt - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_d;
        end
    end

    // Next-cycle view lets the top register its outputs without adding latency.
    assign o_active_next = (w_cnt_d != '0);
    assign o_last        = (r_cnt == PW_BITS'(1));

endmodule

// File: rtl/nim_pulse_pair_gen.sv
// Programmable NIM start/stop pulse-pair generator: one start pulse, then a stop
// pulse D cycles later, per accepted interval word, followed by an optional holdoff.
module nim_pulse_pair_gen
    import nim_pkg::*;
#(
    parameter int unsigned NUM_OUT = NIM_CHANNELS,
    parameter int unsigned PW_BITS = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    nim_pulse_pair_gen_if.slave s_in,
    input  logic               i_enable,
    input  nim_sel_t           i_start_sel,
    input  nim_sel_t           i_stop_sel,
    input  logic [PW_BITS-1:0] i_pulse_width,
    input  logic [31:0]        i_holdoff,
    output logic [NUM_OUT-1:0] o_outputs,
    output logic               o_busy,
    output logic [31:0]        o_pair_count
);

    nim_gen_state_t     r_state, w_state_d;
    logic [31:0]        r_cnt, w_cnt_d;
    logic [31:0]        r_hold;
    logic [PW_BITS-1:0] r_width;
    nim_sel_t           r_start_sel, r_stop_sel;
    logic [31:0]        r_pair_count;
    logic [NUM_OUT-1:0] r_outputs, w_outputs_d;

    logic               w_ready, w_accept, w_stop_fire, w_pair_done;
    logic [PW_BITS-1:0] w_width;
    nim_sel_t           w_start_sel, w_stop_sel;
    logic               w_start_next, w_stop_next, w_start_last, w_stop_last;

    assign w_ready    = (r_state == IDLE) && i_enable && !i_reset;
    assign w_accept   = w_ready && s_in.valid;
    assign s_in.ready = w_ready;

    // Config is taken live in the accept cycle so D=0 and the start pulse see it immediately.
    assign w_width     = !w_accept ? r_width :
                         (i_pulse_width == '0) ? PW_BITS'(1) : i_pulse_width;
    assign w_start_sel = w_accept ? i_start_sel : r_start_sel;
    assign w_stop_sel  = w_accept ? i_stop_sel : r_stop_sel;

    nim_pulse_stretcher #(.PW_BITS(PW_BITS)) u_start (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_fire        (w_accept),
        .i_width       (w_width),
        .o_active_next (w_start_next),
        .o_last        (w_start_last)
    );

    nim_pulse_stretcher #(.PW_BITS(PW_BITS)) u_stop (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_fire        (w_stop_fire),
        .i_width       (w_width),
        .o_active_next (w_stop_next),
        .o_last        (w_stop_last)
    );

    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_stop_fire = 1'b0;
        w_pair_done = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (s_in.data == '0) begin
                        w_stop_fire = 1'b1;
                        w_state_d   = STOP_WAIT;
                    end else begin
                        w_cnt_d   = s_in.data - 32'd1;
                        w_state_d = DELAY;
                    end
                end
            end
            DELAY: begin
                if (r_cnt == '0) begin
                    w_stop_fire = 1'b1;
                    w_state_d   = STOP_WAIT;
                end else begin
                    w_cnt_d = r_cnt - 32'd1;
                end
            end
            STOP_WAIT: begin
                if (w_stop_last) begin
                    w_pair_done = 1'b1;
                    if (r_hold == '0) begin
                        w_state_d = IDLE;
                    end else begin
                        w_cnt_d   = r_hold - 32'd1;
                        w_state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (r_cnt == '0) begin
                    w_state_d = IDLE;
                end else begin
                    w_cnt_d = r_cnt - 32'd1;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_comb begin
        w_outputs_d = '0;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            w_outputs_d[i] = (w_start_next && (w_start_sel == nim_sel_t'(i))) ||
                             (w_stop_next && (w_stop_sel == nim_sel_t'(i)));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_hold       <= '0;
            r_width      <= PW_BITS'(1);
            r_start_sel  <= '0;
            r_stop_sel   <= '0;
            r_pair_count <= '0;
            r_outputs    <= '0;
        end else begin
            r_state   <= w_state_d;
            r_cnt     <= w_cnt_d;
            r_width   <= w_width;
            r_outputs <= w_outputs_d;
            if (w_accept) begin
                r_hold      <= i_holdoff;
                r_start_sel <= i_start_sel;
                r_stop_sel  <= i_stop_sel;
            end
            if (w_pair_done) begin
                r_pair_count <= r_pair_count + 32'd1;
            end
        end
    end

    assign o_outputs    = r_outputs;
    assign o_busy       = (r_state != IDLE);
    assign o_pair_count = r_pair_count;

    logic w_unused;
    assign w_unused = w_start_last;

endmodule

// File: tb/tb_nim_pulse_pair_gen.sv
// Scoreboard bench: stimulus predicts each pair's timeline from the interval rules,
// a negedge monitor compares every cycle and every pair completion.
module tb_nim_pulse_pair_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  ssel = '0;
    logic [1:0]  psel = '0;
    logic [7:0]  pw = '0;
    logic [31:0] hold = '0;
    logic [3:0]  o_out;
    logic        o_busy;
    logic [31:0] o_cnt;

    nim_pulse_pair_gen_if u_if ();

    nim_pulse_pair_gen #(.NUM_OUT(4), .PW_BITS(8)) u_dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .s_in          (u_if),
        .i_enable      (en),
        .i_start_sel   (ssel),
        .i_stop_sel    (psel),
        .i_pulse_width (pw),
        .i_holdoff     (hold),
        .o_outputs     (o_out),
        .o_busy        (o_busy),
        .o_pair_count  (o_cnt)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          free_edge = 0;
    int          en_ok_edge = 0;
    int          cnt_clear_slot = -1;
    bit          chk_on = 1'b0;
    bit [3:0]    exp_out[int];
    bit          exp_busy[int];
    int          pair_q[$];
    int unsigned model_cnt = 0;
    logic [31:0] prev_dut_cnt = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s slot=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    // Slot s = interval after clock edge s; accept on edge A puts the start pulse in slot A.
    always @(negedge clk) begin
        int       s;
        bit [3:0] eo;
        bit       eb;
        bit       popped;
        if (chk_on) begin
            s = cyc;
            if (s == cnt_clear_slot) model_cnt = 0;
            popped = 1'b0;
            while (pair_q.size() > 0 && pair_q[0] <= s) begin
                void'(pair_q.pop_front());
                model_cnt++;
                popped = 1'b1;
            end
            eo = exp_out.exists(s) ? exp_out[s] : 4'b0;
            eb = exp_busy.exists(s) ? exp_busy[s] : 1'b0;
            chk("outputs", 32'(o_out), 32'(eo));
            chk("busy", 32'(o_busy), 32'(eb));
            chk("in_ready", 32'(u_if.ready), 32'(en && !rst && !eb));
            chk("pair_count", o_cnt, 32'(model_cnt));
            if (o_cnt !== prev_dut_cnt && s != cnt_clear_slot) begin
                chk("pair_event", 32'(popped), 32'd1);
            end
            prev_dut_cnt = o_cnt;
        end
    end

    task automatic set_out(input int s, input int b);
        if (!exp_out.exists(s)) exp_out[s] = 4'b0;
        exp_out[s][b] = 1'b1;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int slot);
        while (cyc < slot) step(1);
    endtask

    // Present a word and predict its whole timeline; a = accept edge.
    task automatic offer(input int d, input int p, input int h, input int ss, input int ps,
                         output int a);
        int w;
        u_if.data  = 32'(d);
        pw         = 8'(p);
        hold       = 32'(h);
        ssel       = 2'(ss);
        psel       = 2'(ps);
        u_if.valid = 1'b1;
        a = cyc + 1;
        if (free_edge > a) a = free_edge;
        if (en_ok_edge > a) a = en_ok_edge;
        w = (p == 0) ? 1 : p;
        for (int s = a; s < a + w; s++) set_out(s, ss);
        for (int s = a + d; s < a + d + w; s++) set_out(s, ps);
        for (int s = a; s < a + d + w + h; s++) exp_busy[s] = 1'b1;
        pair_q.push_back(a + d + w);
        free_edge = a + d + w + h + 1;
    endtask

    task automatic scramble();
        u_if.valid = 1'b0;
        u_if.data  = $urandom;
        pw         = 8'($urandom);
        hold       = $urandom;
        ssel       = 2'($urandom);
        psel       = 2'($urandom);
    endtask

    task automatic send(input int d, input int p, input int h, input int ss, input int ps);
        int a;
        offer(d, p, h, ss, ps, a);
        wait_until(a);
        scramble();
    endtask

    task automatic clear_from(input int from);
        int keys[$];
        foreach (exp_out[k]) if (k >= from) keys.push_back(k);
        foreach (keys[i]) exp_out.delete(keys[i]);
        keys.delete();
        foreach (exp_busy[k]) if (k >= from) keys.push_back(k);
        foreach (keys[i]) exp_busy.delete(keys[i]);
        pair_q = pair_q.find(x) with (x < from);
        cnt_clear_slot = from;
    endtask

    initial begin
        int a1, a2, r, rise;
        u_if.valid = 1'b0;
        u_if.data  = '0;
        step(3);
        rst    = 1'b0;
        chk_on = 1'b1;
        step(2);
        en         = 1'b1;
        en_ok_edge = cyc + 1;

        send(10, 4, 0, 0, 1);
        step(2);
        send(0, 3, 0, 2, 2);
        step(1);
        send(2, 5, 0, 0, 3);
        step(3);
        send(5, 0, 20, 0, 1);
        send(5, 0, 20, 2, 3);

        // Enable dropped and config churned mid-pair; queued word waits for enable.
        step(2);
        offer(30, 3, 2, 0, 1, a1);
        wait_until(a1);
        scramble();
        step(3);
        en = 1'b0;
        scramble();
        rise       = a1 + 30 + 3 + 2 + 5;
        en_ok_edge = rise + 1;
        offer(4, 2, 0, 2, 3, a2);
        wait_until(rise);
        en = 1'b1;
        wait_until(a2);
        scramble();

        // Reset in the middle of the stop pulse with a word pending.
        wait_until(free_edge + 2);
        offer(8, 6, 0, 1, 2, a1);
        wait_until(a1);
        scramble();
        wait_until(a1 + 8 + 2);
        r   = cyc;
        rst = 1'b1;
        clear_from(r + 1);
        free_edge = r + 4;
        offer(3, 2, 1, 3, 0, a2);
        step(3);
        rst = 1'b0;
        wait_until(a2);
        scramble();

        for (int i = 0; i < 25; i++) begin
            step($urandom_range(0, 3));
            send($urandom_range(0, 15), $urandom_range(0, 5), $urandom_range(0, 6),
                 $urandom_range(0, 3), $urandom_range(0, 3));
        end

        wait_until(free_edge + 3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog slot=%0d actual=running required=finished", cyc);
        $fatal(1);
    end

endmodule

// File: doc/nim_pulse_pair_gen.md
# nim_pulse_pair_gen

Programmable NIM start/stop pulse-pair generator, the transmit-side counterpart of the NIM time-to-amplitude measurement path. Host firmware pushes 32-bit interval words over a valid/ready stream. For each word the block drives a start pulse, then a stop pulse exactly that many clock cycles later, onto selectable NIM output lines. It is used for closed-loop calibration of timing channels and as a standalone test-pulse source.

## Interface
- `NUM_OUT`, 4: number of NIM output lines.
- `PW_BITS`, 8: width of the pulse-width setting.
- `clk` in 1: single system clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: gates acceptance of new interval words only.
- `start_sel` in 2: output index driven by the start pulse.
- `stop_sel` in 2: output index driven by the stop pulse.
- `pulse_width` in PW_BITS: pulse high time in cycles; 0 is treated as 1.
- `holdoff` in 32: idle cycles enforced after a stop pulse ends.
- `in_data` in 32: interval D, in cycles from start rising edge to stop rising edge.
- `in_valid` in 1: interval word present.
- `in_ready` out 1: block can accept a word.
- `outputs` out NUM_OUT: registered NIM-level pulse outputs, active-high.
- `busy` out 1: a pulse pair or holdoff is in progress.
- `pair_count` out 32: completed pairs; wraps modulo 2^32.

## Operation
- FSM states: IDLE, DELAY, STOP_WAIT, HOLD.
- IDLE:
  - `in_ready` = `enable`.
  - On `in_valid && in_ready`, latch D, W = max(`pulse_width`,1), H = `holdoff`, `start_sel` and `stop_sel`. Fire the start stretcher. Go to DELAY.
- DELAY:
  - Count D cycles from accept, then fire the stop stretcher and go to STOP_WAIT.
  - D=0 fires the stop stretcher in the accept cycle itself.
- STOP_WAIT:
  - Wait until the stop pulse's last high cycle.
  - Increment `pair_count` on that cycle.
  - Go to HOLD, or to IDLE if H=0.
- HOLD: count H cycles, then go to IDLE.
- Start and stop stretchers are independent. Pulses may overlap when D < W.
- `outputs[i]` = (start active && start_sel==i) OR (stop active && stop_sel==i). With equal selects, overlapping pulses merge.
- Config inputs are sampled only at accept. Later changes do not affect an in-flight pair.
- Deasserting `enable` mid-pair does not abort it. Only `reset` aborts.
- `busy` = state != IDLE.
- Reset value of every output is 0: `outputs`, `in_ready`, `busy`, `pair_count`. State returns to IDLE and both stretchers clear.
- Reset mid-pulse drops outputs to 0 on the next edge. A pending word is not consumed.

## Timing
- Accept on edge T (`in_valid && in_ready` sampled high).
- Start output is high for cycles T+1 … T+W.
- Stop output is high for cycles T+1+D … T+D+W.
- `pair_count` updates visible at T+D+W+1.
- `in_ready` is high again no earlier than cycle T+D+W+1+H.
  - With H=0, a back-to-back next start rises at T+D+W+2.
  - This guarantees at least one low cycle on a shared output line.
- D range is 0 … 2^32−1. Counters are 32-bit and must not wrap within a pair.
- Throughput is one pair per D+W+H+1 cycles minimum.

## Structure
- Shared package `nim_pkg`:
  - `NIM_CHANNELS` = 4.
  - typedef `nim_gen_state_t` enum {IDLE, DELAY, STOP_WAIT, HOLD}.
  - typedef `nim_sel_t` = logic [1:0].
- Sub-module `nim_pulse_stretcher`: one-shot with a `fire` input and a latched width W. It drives `active` for exactly W cycles starting the cycle after `fire`. A re-fire while active restarts the count. It is instantiated twice (start, stop).
- The top holds the FSM, the delay/holdoff counter and the output mux.

## Test plan
- Basic pair: W=4, D=10, H=0, start_sel=0, stop_sel=1, accept at T.
  - Required: outputs[0] high T+1…T+4; outputs[1] high T+11…T+14.
  - pair_count=1 at T+15; in_ready high at T+15.
- Overlap and zero delay, same select: D=0, W=3, sel 2/2.
  - Required: outputs[2] high T+1…T+3 only.
- Overlap, different selects: D=2, W=5, sel 0/3.
  - Required: outputs[0] high T+1…T+5; outputs[3] high T+3…T+7.
- pulse_width=0 plus holdoff: W→1, H=20, D=5.
  - Required: in_ready low through T+26 and high at T+27.
  - Two queued words give start edges 27 cycles apart.
- Enable and config changes mid-pair: deassert enable and change sel/pulse_width during DELAY.
  - Required: the in-flight pair completes with the latched values.
  - No new accept until enable returns.
- Reset mid-stop-pulse:
  - Required: all outputs 0 the next cycle; FSM in IDLE; pair_count 0.
  - The word held on in_valid is accepted only after reset is released and enable=1.
